// File: rtl/dropoff_balancer_multi.sv
// N-channel drop-off balancer: per channel, contribution s and train limit l from one shared signed divider.
// One sweep takes 2 + sum(enabled ? 6*(WB+1)+1 : 1) cycles; outputs are held until each channel's COMMIT.
module dropoff_balancer_multi #(
  parameter int N   = 2,
  parameter int INT = 31
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N-1:0]           chan_en,
  input  logic [N*(INT+1)-1:0]   p,
  input  logic [N*(INT+1)-1:0]   g,
  input  logic [N*(INT+1)-1:0]   r,
  input  logic [N*(INT+1)-1:0]   u,
  input  logic [N*(INT+1)-1:0]   c,
  input  logic [N*(INT+1)-1:0]   t,
  input  logic [N*(INT+1)-1:0]   q,
  input  logic [N*(INT+1)-1:0]   m,
  input  logic [N*(INT+1)-1:0]   w,
  output logic [N*(INT+1)-1:0]   s,
  output logic [N*(INT+1)-1:0]   l,
  output logic                   busy,
  output logic                   sweep_done
);

  localparam int WB = INT + 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(WB + 1);

  typedef logic signed [INT:0] word_t;
  typedef enum logic [2:0] {IDLE, SAMPLE, DIV, COMMIT, DONE} state_t;

  state_t         state;
  word_t          sh_p [N];
  word_t          sh_g [N];
  word_t          sh_r [N];
  word_t          sh_u [N];
  word_t          sh_c [N];
  word_t          sh_t [N];
  word_t          sh_q [N];
  word_t          sh_m [N];
  word_t          sh_w [N];
  logic [N-1:0]   sh_en;
  logic [CW-1:0]  ch;
  logic [2:0]     div_idx;
  logic [SW-1:0]  div_step;
  logic [INT:0]   quo;
  logic [INT:0]   rem;
  logic [INT:0]   dvs_mag;
  logic           div_neg;
  logic           div_zero;
  word_t          v_q, s_q, x_q, h_q, y_q, o_q;

  word_t          p_c, g_c, r_c, u_c, c_c, t_c, q_c, m_c, w_c;
  word_t          a_c, dvd, dvs, nn, e_val, l_val, q_fin;
  logic [INT:0]   dvd_mag;
  logic [INT+1:0] rem_sh, diff;
  logic [INT:0]   quo_nxt;

  always_comb begin
    p_c = sh_p[ch];
    g_c = sh_g[ch];
    r_c = sh_r[ch];
    u_c = sh_u[ch];
    c_c = sh_c[ch];
    t_c = sh_t[ch];
    q_c = sh_q[ch];
    m_c = sh_m[ch];
    w_c = sh_w[ch];
    a_c = u_c + (c_c - word_t'(t_c != '0)) * w_c;

    // Operands for the six divisions, in order V, S, X, H, Y, O.
    dvd = '0;
    dvs = '0;
    case (div_idx)
      3'd0: begin dvd = r_c;               dvs = g_c; end
      3'd1: begin dvd = a_c * p_c;         dvs = m_c; end
      3'd2: begin dvd = u_c * p_c;         dvs = m_c; end
      3'd3: begin dvd = m_c - a_c;         dvs = w_c; end
      3'd4: begin dvd = (v_q - x_q) * m_c; dvs = p_c; end
      default: begin dvd = y_q;            dvs = w_c; end
    endcase
    dvd_mag = dvd[INT] ? -dvd : dvd;

    rem_sh  = {rem, quo[INT]};
    diff    = rem_sh - {1'b0, dvs_mag};
    quo_nxt = {quo[INT-1:0], ~diff[INT+1]};
    q_fin   = div_zero ? '0 : (div_neg ? -quo_nxt : quo_nxt);

    nn    = o_q + word_t'(o_q == '0);
    e_val = (h_q < nn) ? h_q : nn;
    if (q_c < e_val) e_val = q_c;
    l_val = (v_q >= x_q) ? e_val : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      sweep_done <= 1'b0;
      s          <= '0;
      l          <= '0;
      sh_en      <= '0;
      ch         <= '0;
      div_idx    <= '0;
      div_step   <= '0;
      quo        <= '0;
      rem        <= '0;
      dvs_mag    <= '0;
      div_neg    <= 1'b0;
      div_zero   <= 1'b0;
      v_q <= '0; s_q <= '0; x_q <= '0; h_q <= '0; y_q <= '0; o_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state <= SAMPLE;
            busy  <= 1'b1;
          end
        end
        SAMPLE: begin
          for (int k = 0; k < N; k++) begin
            sh_p[k] <= p[k*WB +: WB];
            sh_g[k] <= g[k*WB +: WB];
            sh_r[k] <= r[k*WB +: WB];
            sh_u[k] <= u[k*WB +: WB];
            sh_c[k] <= c[k*WB +: WB];
            sh_t[k] <= t[k*WB +: WB];
            sh_q[k] <= q[k*WB +: WB];
            sh_m[k] <= m[k*WB +: WB];
            sh_w[k] <= w[k*WB +: WB];
          end
          sh_en    <= chan_en;
          ch       <= '0;
          div_idx  <= '0;
          div_step <= '0;
          state    <= chan_en[0] ? DIV : COMMIT;
        end
        DIV: begin
          if (div_step == '0) begin
            quo      <= dvd_mag;
            rem      <= '0;
            dvs_mag  <= dvs[INT] ? -dvs : dvs;
            div_neg  <= dvd[INT] ^ dvs[INT];
            div_zero <= (dvs == '0);
            div_step <= div_step + 1'b1;
          end else begin
            rem <= diff[INT+1] ? rem_sh[INT:0] : diff[INT:0];
            quo <= quo_nxt;
            if (div_step == SW'(WB)) begin
              case (div_idx)
                3'd0:    v_q <= q_fin;
                3'd1:    s_q <= q_fin;
                3'd2:    x_q <= q_fin;
                3'd3:    h_q <= q_fin;
                3'd4:    y_q <= q_fin;
                default: o_q <= q_fin;
              endcase
              div_step <= '0;
              if (div_idx == 3'd5) begin
                div_idx <= '0;
                state   <= COMMIT;
              end else begin
                div_idx <= div_idx + 1'b1;
              end
            end else begin
              div_step <= div_step + 1'b1;
            end
          end
        end
        COMMIT: begin
          s[int'(ch)*WB +: WB] <= sh_en[ch] ? s_q : '0;
          l[int'(ch)*WB +: WB] <= sh_en[ch] ? l_val : '0;
          if (ch == CW'(N - 1)) begin
            state      <= DONE;
            sweep_done <= 1'b1;
          end else begin
            ch    <= ch + 1'b1;
            state <= sh_en[ch + 1'b1] ? DIV : COMMIT;
          end
        end
        DONE: begin
          sweep_done <= 1'b0;
          if (en) begin
            state <= SAMPLE;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dropoff_balancer_multi.md
# dropoff_balancer_multi

Sequential, N-channel successor to the single-resource drop-off station balancer. One instance serves one train stop that receives N resources, each with its own global network (P, G, R) and its own station config (Q, M, W). It computes each channel's contribution S and train limit L. A single shared iterative signed divider is time-multiplexed over all channels, so the outputs are registered and refreshed once per sweep rather than combinationally.

## Interface
- `N`, 2: number of resource channels (1..16)
- `INT`, 31: MSB index; every signal is INT+1-bit two's complement (`WB` = INT+1)
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  run sweeps continuously while high
- `chan_en`  in  N  per-channel enable; a disabled channel commits s=l=0
- `p`, `g`, `r`  in  N*WB  per-channel precision, station count, total percentage (global networks)
- `u`, `c`, `t`  in  N*WB  per-channel stored units, trains en route count, train at stop
- `q`, `m`, `w`  in  N*WB  per-channel queue limit, max storage, units per train load
- `s`  out  N*WB  per-channel contribution to global percentage
- `l`  out  N*WB  per-channel train limit
- `busy`  out  1  high in every state except IDLE
- `sweep_done`  out  1  one-cycle pulse when all channels have committed

## Operation
- Channel k occupies bits [k*WB +: WB] of every packed port.
- Arithmetic rules:
  - Multiply, add and subtract wrap to WB bits.
  - Divide truncates toward zero; divisor 0 gives quotient 0.
  - Every comparison is signed.
- Per-channel computation on sampled values:
  - A = U + (C − (T≠0 ? 1 : 0))·W
  - S = A·P/M
  - X = U·P/M
  - V = R/G
  - H = (M − A)/W
  - D = V − X
  - O = (D·M/P)/W
  - Nn = O + (O==0 ? 1 : 0)
  - E = min(min(H, Nn), Q)
  - L = (V ≥ X) ? E : 0
- FSM states: IDLE, SAMPLE, DIV, COMMIT, DONE.
  - IDLE: leave when en=1, going to SAMPLE.
  - SAMPLE (1 cycle): latches all inputs, including chan_en, into shadow registers. Input changes after this cycle are ignored until the next SAMPLE.
  - DIV, once per enabled channel: six divisions in the fixed order V, S, X, H, Y(=D·M/P), O, each taking exactly WB+1 cycles (1 load cycle + WB restoring steps). The quotient is captured on the last step.
  - COMMIT (1 cycle per channel, enabled or not): writes s[k] and l[k] together. A disabled channel skips DIV and writes 0/0.
  - DONE (1 cycle): sweep_done=1, then SAMPLE if en=1, else IDLE.
- en falling mid-sweep: the current sweep completes; the FSM then goes to IDLE.
- Channels are processed in ascending k. Uncommitted channels hold their previous-sweep values.
- The divider's sign handling uses magnitudes plus a sign fix-up. Dividing the most-negative value by −1 wraps to the most-negative value.

## Timing
- Reset values: s=0, l=0, busy=0, sweep_done=0, FSM in IDLE, divider cleared.
- Reset asserted in any state aborts the sweep and applies the reset values on the next edge.
- en sampled high in IDLE at edge e: SAMPLE is active in cycle e+1.
- Sweep length from SAMPLE to DONE inclusive: 2 + Σk (chan_en[k] ? 6·(WB+1)+1 : 1) cycles.
  - All enabled, N=2, INT=31: 400 cycles.
- s[k]/l[k] change on the edge that ends channel k's COMMIT.
- With en held high, sweep_done pulses every sweep-length cycles and busy stays high.

## Test plan
- **Nominal:** N=2, INT=31, ch0 Q=3, M=128000, W=8000, P=100, G=2, R=100, U=40000, C=1, T=0 → s0=37, l0=3.
- **Train at stop:** ch0 as nominal but T=1 → s0=31, l0=3. **Over-share:** U=100000, T=1, R=50 → s0=78, l0=0.
- **O==0 floor:** U=40000, C=1, T=1, R=64, G=2 → l=1.
- **Divide by zero:** G=0 → l=0, no X/hang.
- **Timing:** en pulses one cycle in IDLE, both channels enabled → SAMPLE next cycle, sweep_done exactly 400 cycles after SAMPLE entry, busy low afterward. chan_en=2'b10 → sweep 202 cycles, s0=l0=0.
- **Reset mid-sweep:** rst at cycle 150 of a sweep → next cycle all outputs 0 and IDLE. Re-enable → correct values on the next full sweep.
